// File: rtl/fifo_write_arbiter.sv
// Four-requester packet arbiter that feeds one FIFO write port, round-robin between packets.
// Define WARB_STATS_EN to add the saturating pkt_cnt completed-packet counter.
module fifo_write_arbiter #(
  parameter int DSIZE = 8
) (
  input  logic               wclk,
  input  logic               wrst,
  input  logic [3:0]         req,
  input  logic [3:0]         last,
  input  logic [4*DSIZE-1:0] din,
  input  logic               wfull,
  output logic [3:0]         gnt,
  output logic [DSIZE-1:0]   wdata,
  output logic               winc,
  output logic [1:0]         owner,
  output logic               busy
`ifdef WARB_STATS_EN
  ,
  output logic [15:0]        pkt_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] rr_q, rr_d;
  logic       accept;
  logic       done;
  logic       found;
  logic [1:0] pick;
  logic [1:0] idx;

  // first requester at or after rr_q, wrapping past 3
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    idx   = rr_q;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign accept = (state_q == LOCK) && req[owner_q] && !wfull;
  assign done   = accept && last[owner_q];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (done) begin
          state_d = IDLE;
          rr_d    = owner_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      rr_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  assign winc  = accept;
  assign gnt   = accept ? (4'b0001 << owner_q) : 4'b0000;
  assign wdata = din[owner_q*DSIZE +: DSIZE];
  assign owner = owner_q;
  assign busy  = (state_q == LOCK);

`ifdef WARB_STATS_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      pkt_cnt_q <= 16'd0;
    end else if (done && (pkt_cnt_q != 16'hFFFF)) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed bench for fifo_write_arbiter against a packet-level model.
// Build with WARB_STATS_EN to also cover the packet counter.
module tb_fifo_write_arbiter;

  localparam int DSIZE = 8;

  logic               wclk;
  logic               wrst;
  logic [3:0]         req;
  logic [3:0]         last;
  logic [4*DSIZE-1:0] din;
  logic               wfull;
  logic [3:0]         gnt;
  logic [DSIZE-1:0]   wdata;
  logic               winc;
  logic [1:0]         owner;
  logic               busy;
`ifdef WARB_STATS_EN
  logic [15:0]        pkt_cnt;
`endif

  fifo_write_arbiter #(.DSIZE(DSIZE)) dut (
    .wclk  (wclk),
    .wrst  (wrst),
    .req   (req),
    .last  (last),
    .din   (din),
    .wfull (wfull),
    .gnt   (gnt),
    .wdata (wdata),
    .winc  (winc),
    .owner (owner),
    .busy  (busy)
`ifdef WARB_STATS_EN
    ,
    .pkt_cnt (pkt_cnt)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_err = 0;

  // model: is a packet in progress, who owns it, where priority starts
  bit m_lock;
  int m_own;
  int m_rr;
  int m_cnt;

  int wr_seen;
  logic [3:0] gnt_log[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = 0;
    m_own  = 0;
    m_rr   = 0;
    m_cnt  = 0;
  endtask

  // one clock: drive at negedge, check before posedge, advance model
  task automatic cycle(input logic [3:0] r, input logic [3:0] l,
                       input logic f);
    bit acc;
    logic [3:0] eg;
    req   = r;
    last  = l;
    wfull = f;
    din   = $urandom;
    #1;
    acc = m_lock && r[m_own] && !f;
    eg  = acc ? 4'(1 << m_own) : 4'b0;
    chk("gnt", gnt, eg);
    chk("winc", winc, acc);
    chk("busy", busy, m_lock);
    chk("owner", owner, m_own);
    chk("wdata", wdata, din[m_own*DSIZE +: DSIZE]);
`ifdef WARB_STATS_EN
    chk("pkt_cnt", pkt_cnt, m_cnt);
`endif
    gnt_log.push_back(gnt);
    if (acc) wr_seen++;
    @(posedge wclk);
    if (!m_lock) begin
      if (r != 0) begin
        for (int k = 0; k < 4; k++) begin
          if (!m_lock && r[(m_rr + k) % 4]) begin
            m_own  = (m_rr + k) % 4;
            m_lock = 1;
          end
        end
      end
    end else if (acc && l[m_own]) begin
      m_lock = 0;
      m_rr   = (m_own + 1) % 4;
      if (m_cnt < 16'hFFFF) m_cnt++;
    end
    @(negedge wclk);
  endtask

  task automatic do_reset();
    #2;
    wrst = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_winc", winc, 1'b0);
    chk("rst_gnt", gnt, 4'b0);
    chk("rst_owner", owner, 2'd0);
    model_reset();
    req  = 4'b0;
    last = 4'b0;
    @(negedge wclk);
    @(negedge wclk);
    wrst = 1'b0;
  endtask

  initial begin
    wrst  = 1'b1;
    req   = 4'b0;
    last  = 4'b0;
    din   = '0;
    wfull = 1'b0;
    model_reset();
    @(negedge wclk);
    #1;
    chk("por_busy", busy, 1'b0);
    chk("por_gnt", gnt, 4'b0);
    @(negedge wclk);
    wrst = 1'b0;

    // single requester, 3-beat packet
    wr_seen = 0;
    cycle(4'b0001, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0001, 1'b0);
    chk("single_writes", wr_seen, 3);
    chk("single_idle", busy, 1'b0);
    // rr_ptr is now 1: with 0 and 1 requesting, 1 wins
    cycle(4'b0011, 4'b0000, 1'b0);
    chk("single_rr", owner, 2'd1);
    do_reset();

    // round robin with single-beat packets
    gnt_log.delete();
    for (int i = 0; i < 10; i++) cycle(4'b1111, 4'b1111, 1'b0);
    for (int i = 0; i < 10; i++)
      chk("rr_gnt", gnt_log[i],
          (i % 2) ? 4'(1 << ((i / 2) % 4)) : 4'b0);
    do_reset();

    // full stall on owner 2
    wr_seen = 0;
    cycle(4'b0100, 4'b0000, 1'b0);
    cycle(4'b0100, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) cycle(4'b0100, 4'b0100, 1'b1);
    chk("stall_owner", owner, 2'd2);
    cycle(4'b0100, 4'b0000, 1'b0);
    cycle(4'b0100, 4'b0100, 1'b0);
    chk("stall_writes", wr_seen, 3);
    do_reset();

    // owner 1 gap while others request
    wr_seen = 0;
    cycle(4'b0010, 4'b0000, 1'b0);
    cycle(4'b0010, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) cycle(4'b1001, 4'b1111, 1'b0);
    chk("gap_busy", busy, 1'b1);
    chk("gap_writes", wr_seen, 1);
    cycle(4'b1011, 4'b0010, 1'b0);
    chk("gap_done", busy, 1'b0);
    do_reset();

    // reset mid-packet from requester 3
    cycle(4'b1000, 4'b0000, 1'b0);
    cycle(4'b1000, 4'b0000, 1'b0);
    req = 4'b1000;
    do_reset();
    cycle(4'b1001, 4'b0000, 1'b0);
    chk("rst_restart", owner, 2'd0);
    do_reset();

`ifdef WARB_STATS_EN
    for (int i = 0; i < 6; i++) cycle(4'b0101, 4'b0101, 1'b0);
    chk("cnt3", pkt_cnt, 16'd3);
    force dut.pkt_cnt_q = 16'hFFFE;
    #1;
    release dut.pkt_cnt_q;
    m_cnt = 16'hFFFE;
    for (int i = 0; i < 6; i++) cycle(4'b0101, 4'b0101, 1'b0);
    chk("cnt_sat", pkt_cnt, 16'hFFFF);
    do_reset();
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(4'($urandom), 4'($urandom) & 4'($urandom),
            ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, giving the data width of each requester beat and of the FIFO write word.
REQ-002 The block SHALL have a fixed requester count of 4, indexed 0..3.
REQ-003 The block SHALL have port wclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port wrst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req, input, 4 bits: per-requester beat valid.
REQ-006 The block SHALL have port last, input, 4 bits: per-requester final beat of a packet, qualified by req.
REQ-007 The block SHALL have port din, input, 4*DSIZE bits: requester i data on bits [i*DSIZE +: DSIZE].
REQ-008 The block SHALL have port wfull, input, 1 bit: the FIFO write-side full flag.
REQ-009 The block SHALL have port gnt, output, 4 bits: one-hot beat-accepted strobe per requester.
REQ-010 The block SHALL have port wdata, output, DSIZE bits: FIFO write data.
REQ-011 The block SHALL have port winc, output, 1 bit: FIFO write enable.
REQ-012 The block SHALL have port owner, output, 2 bits: index of the locked requester.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in state LOCK.

Function
REQ-014 The FSM SHALL have two states: IDLE and LOCK.
REQ-015 In IDLE with req nonzero, the FSM SHALL select the first requesting index, searching circularly from rr_ptr upward, register it into owner, and move to LOCK on the next edge.
REQ-016 In IDLE, winc and gnt SHALL be 0, giving a fixed one-cycle arbitration bubble per packet.
REQ-017 In LOCK, the combinational accept SHALL be req[owner] AND NOT wfull.
REQ-018 In LOCK, winc SHALL equal accept and gnt SHALL equal accept shifted to bit owner, in the same cycle with no register stage.
REQ-019 wdata SHALL equal din slice owner, combinationally, in every state.
REQ-020 When accept and last[owner] are both high, the FSM SHALL return to IDLE and set rr_ptr to owner+1 modulo 4, wrapping 3 to 0.
REQ-021 In LOCK with req[owner] low, the FSM SHALL hold LOCK and owner indefinitely; there is no timeout.
REQ-022 In LOCK with wfull high, winc and gnt SHALL be 0 and all state SHALL be held; an asserted last is consumed only when accepted.
REQ-023 In LOCK, req and last from non-owner requesters SHALL be ignored.
REQ-024 A single-beat packet (req and last high together) SHALL complete in one LOCK cycle.
REQ-025 At most one gnt bit SHALL be high in any cycle, and gnt SHALL never be high while wfull is high.

Reset
REQ-026 While wrst is high, the FSM SHALL be IDLE, owner SHALL be 0, rr_ptr SHALL be 0, and busy, winc and gnt SHALL be 0, independent of wclk.
REQ-027 A reset asserted mid-packet SHALL abandon the packet with no further writes; after release, arbitration SHALL restart with priority at requester 0.

Configuration
REQ-028 With macro WARB_STATS_EN defined, the block SHALL add output pkt_cnt, 16 bits, reset to 0, which increments on each completed packet (accept with last) and saturates at 0xFFFF.
REQ-029 Without WARB_STATS_EN, the pkt_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Single requester: req=0001, din0=0xA5 with last on the 3rd beat, wfull=0 -> busy rises 1 cycle later, winc high for 3 consecutive cycles with wdata=din0 each cycle, then IDLE, rr_ptr=1.
REQ-031 Round-robin: req=1111 held, every beat has last=1 -> owner sequence 0,1,2,3,0, each packet separated by one idle cycle.
REQ-032 Full stall: in LOCK on owner 2, raise wfull for 5 cycles mid-packet -> winc=0 and gnt=0 for those 5 cycles, owner stays 2, and transfer resumes the cycle after wfull falls.
REQ-033 Owner gap: owner 1 drops req for 4 cycles mid-packet while req[0] and req[3] stay high -> busy stays 1, owner stays 1, no writes occur, and the packet completes once req[1] returns.
REQ-034 Reset mid-packet: assert wrst during beat 2 of a 4-beat packet from requester 3 -> outputs go to 0 immediately; after release with req=1001, owner=0 is chosen first.
REQ-035 With WARB_STATS_EN defined, complete 3 packets -> pkt_cnt=3; force the counter to 0xFFFE and complete 2 more packets -> pkt_cnt=0xFFFF.
